// File: rtl/bp_nonsynth_commit_packer_if.sv
// Commit-packer bus bundle.
//   commit_*  : retirement stream from the core, with ready_o back-pressure
//   late_wb_* : late integer writeback stream (e.g. long-latency results)
//   pkt_*     : packed commit packet to the consumer, valid/yumi handshake
// master = core/consumer side, slave = the packer.
interface bp_nonsynth_commit_packer_if #(
    parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32,
    parameter int dword_width_p = 64
);
    logic                     commit_v_i;
    logic [vaddr_width_p-1:0] commit_pc_i;
    logic [instr_width_p-1:0] commit_instr_i;
    logic                     commit_rd_w_v_i;
    logic [4:0]               commit_rd_addr_i;
    logic                     commit_late_i;
    logic [dword_width_p-1:0] commit_data_i;
    logic                     ready_o;

    logic                     late_wb_v_i;
    logic [4:0]               late_wb_addr_i;
    logic [dword_width_p-1:0] late_wb_data_i;

    logic                     pkt_v_o;
    logic                     pkt_yumi_i;
    logic [vaddr_width_p-1:0] pkt_pc_o;
    logic [instr_width_p-1:0] pkt_instr_o;
    logic                     pkt_rd_w_v_o;
    logic [4:0]               pkt_rd_addr_o;
    logic [dword_width_p-1:0] pkt_rd_data_o;

    modport master (
        output commit_v_i, commit_pc_i, commit_instr_i, commit_rd_w_v_i,
               commit_rd_addr_i, commit_late_i, commit_data_i,
               late_wb_v_i, late_wb_addr_i, late_wb_data_i, pkt_yumi_i,
        input  ready_o, pkt_v_o, pkt_pc_o, pkt_instr_o, pkt_rd_w_v_o,
               pkt_rd_addr_o, pkt_rd_data_o
    );

    modport slave (
        input  commit_v_i, commit_pc_i, commit_instr_i, commit_rd_w_v_i,
               commit_rd_addr_i, commit_late_i, commit_data_i,
               late_wb_v_i, late_wb_addr_i, late_wb_data_i, pkt_yumi_i,
        output ready_o, pkt_v_o, pkt_pc_o, pkt_instr_o, pkt_rd_w_v_o,
               pkt_rd_addr_o, pkt_rd_data_o
    );
endinterface

// File: rtl/bp_nonsynth_commit_packer.sv
// Commit packer: buffers retired instructions in order and emits one packet
// per commit once its rd data is known. Early data travels with the commit;
// late data is picked up from a 32-entry table filled by the late writeback
// port and consumed (valid cleared) when the packet is taken.
// Ports:
//   clk_i, reset_n_i : clock, async active-low reset
//   bus (slave)      : commit stream + ready_o, late writeback, packet out
//   count_o          : number of buffered commits
//   err_o            : sticky protocol error (drop when full, yumi without
//                      valid, late write to an already-valid register)
module bp_nonsynth_commit_packer #(
    parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32,
    parameter int dword_width_p = 64,
    parameter int els_p         = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    bp_nonsynth_commit_packer_if.slave   bus,
    output logic [$clog2(els_p):0]       count_o,
    output logic                         err_o
);
    localparam int lg_els_lp = $clog2(els_p);
    localparam logic [lg_els_lp:0] full_cnt_lp = (lg_els_lp+1)'(els_p);

    typedef struct packed {
        logic [vaddr_width_p-1:0] pc;
        logic [instr_width_p-1:0] instr;
        logic                     rd_w_v;
        logic [4:0]               rd_addr;
        logic                     late;
        logic [dword_width_p-1:0] data;
    } entry_s;

    entry_s                   mem [els_p];
    entry_s                   head, wr_entry;
    logic [lg_els_lp-1:0]     wr_ptr, rd_ptr;
    logic [31:0]              tbl_v;
    logic [dword_width_p-1:0] tbl_data [32];

    logic ready, pkt_v, push, pop, late_wr, head_clr, overwrite;

    assign head     = mem[rd_ptr];
    assign ready    = (count_o != full_cnt_lp);
    assign pkt_v    = (count_o != '0) && (!head.late || tbl_v[head.rd_addr]);
    assign push     = bus.commit_v_i & ready;
    assign pop      = bus.pkt_yumi_i & pkt_v;
    assign late_wr  = bus.late_wb_v_i && (bus.late_wb_addr_i != 5'd0);
    assign head_clr = pop && head.late;
    // A write landing on the register being consumed this edge is a fresh
    // result for a younger commit, not a protocol violation.
    assign overwrite = late_wr && tbl_v[bus.late_wb_addr_i]
                       && !(head_clr && (head.rd_addr == bus.late_wb_addr_i));

    // x0 never carries a write: strip the flags and data so the packet is
    // emitted immediately and reads as "no rd write".
    always_comb begin
        wr_entry         = '0;
        wr_entry.pc      = bus.commit_pc_i;
        wr_entry.instr   = bus.commit_instr_i;
        wr_entry.rd_addr = bus.commit_rd_addr_i;
        if (bus.commit_rd_addr_i != 5'd0) begin
            wr_entry.rd_w_v = bus.commit_rd_w_v_i;
            wr_entry.late   = bus.commit_late_i;
            wr_entry.data   = bus.commit_data_i;
        end
    end

    assign bus.ready_o       = ready;
    assign bus.pkt_v_o       = pkt_v;
    assign bus.pkt_pc_o      = head.pc;
    assign bus.pkt_instr_o   = head.instr;
    assign bus.pkt_rd_w_v_o  = head.rd_w_v;
    assign bus.pkt_rd_addr_o = head.rd_addr;
    assign bus.pkt_rd_data_o = head.late ? tbl_data[head.rd_addr] : head.data;

    // Payload storage carries no reset; occupancy is tracked by count_o.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk_i) begin
        if (late_wr) tbl_data[bus.late_wb_addr_i] <= bus.late_wb_data_i;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
            tbl_v   <= '0;
            err_o   <= 1'b0;
        end else begin
            // Pointers are lg_els_lp bits wide, so they wrap for free.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count_o <= count_o + (lg_els_lp+1)'(push) - (lg_els_lp+1)'(pop);
            // Set after clear so a same-register write wins.
            if (head_clr) tbl_v[head.rd_addr] <= 1'b0;
            if (late_wr)  tbl_v[bus.late_wb_addr_i] <= 1'b1;
            if ((bus.commit_v_i && !ready) || (bus.pkt_yumi_i && !pkt_v) || overwrite)
                err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bp_nonsynth_commit_packer.sv
module tb_bp_nonsynth_commit_packer;
    logic       clk_i = 1'b0;
    logic       reset_n_i = 1'b0;
    logic [3:0] count_o;
    logic       err_o;
    int         checks = 0;
    int         errors = 0;

    always #5 clk_i = ~clk_i;

    bp_nonsynth_commit_packer_if #(.vaddr_width_p(39), .instr_width_p(32), .dword_width_p(64)) bus_if ();

    bp_nonsynth_commit_packer #(.vaddr_width_p(39), .instr_width_p(32), .dword_width_p(64), .els_p(8)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .bus(bus_if), .count_o(count_o), .err_o(err_o)
    );

    typedef struct {
        bit          cv;   logic [38:0] pc;  logic [4:0] rd;  bit late; logic [63:0] d;
        bit          lv;   logic [4:0]  la;  logic [63:0] ld; bit y;
        bit          pv;   int          cnt; bit rdy;         bit err;
        bit          chk;  logic [38:0] epc; bit erdw;        logic [4:0] erd; logic [63:0] ed;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(bit cv, logic [38:0] pc, logic [4:0] rd, bit late, logic [63:0] d,
                               bit lv, logic [4:0] la, logic [63:0] ld, bit y,
                               bit pv, int cnt, bit rdy, bit err,
                               bit chk, logic [38:0] epc, bit erdw, logic [4:0] erd, logic [63:0] ed);
        vec_t r;
        r.cv = cv; r.pc = pc; r.rd = rd; r.late = late; r.d = d;
        r.lv = lv; r.la = la; r.ld = ld; r.y = y;
        r.pv = pv; r.cnt = cnt; r.rdy = rdy; r.err = err;
        r.chk = chk; r.epc = epc; r.erdw = erdw; r.erd = erd; r.ed = ed;
        return r;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t x);
        bus_if.commit_v_i       = x.cv;
        bus_if.commit_pc_i      = x.pc;
        bus_if.commit_instr_i   = x.pc[31:0] ^ 32'h13;
        bus_if.commit_rd_w_v_i  = x.cv;
        bus_if.commit_rd_addr_i = x.rd;
        bus_if.commit_late_i    = x.late;
        bus_if.commit_data_i    = x.d;
        bus_if.late_wb_v_i      = x.lv;
        bus_if.late_wb_addr_i   = x.la;
        bus_if.late_wb_data_i   = x.ld;
        bus_if.pkt_yumi_i       = x.y;
    endtask

    task automatic idle_inputs();
        drive(v(0,0,0,0,0, 0,0,0, 0, 0,0,0,0, 0,0,0,0,0));
    endtask

    task automatic expect_state(string tag, vec_t x);
        check({tag, ".pkt_v"}, 64'(bus_if.pkt_v_o), 64'(x.pv));
        check({tag, ".count"}, 64'(count_o), 64'(x.cnt));
        check({tag, ".ready"}, 64'(bus_if.ready_o), 64'(x.rdy));
        check({tag, ".err"}, 64'(err_o), 64'(x.err));
        if (x.chk) begin
            check({tag, ".pc"}, 64'(bus_if.pkt_pc_o), 64'(x.epc));
            check({tag, ".instr"}, 64'(bus_if.pkt_instr_o), 64'(x.epc[31:0] ^ 32'h13));
            check({tag, ".rd_w_v"}, 64'(bus_if.pkt_rd_w_v_o), 64'(x.erdw));
            check({tag, ".rd"}, 64'(bus_if.pkt_rd_addr_o), 64'(x.erd));
            check({tag, ".data"}, bus_if.pkt_rd_data_o, x.ed);
        end
    endtask

    // One cycle: inputs driven at negedge, state checked #1 after the edge.
    task automatic apply(string tag, vec_t x);
        @(negedge clk_i);
        drive(x);
        @(posedge clk_i);
        #1;
        idle_inputs();
        expect_state(tag, x);
    endtask

    task automatic async_reset_pulse(string tag);
        vec_t r;
        r = v(0,0,0,0,0, 0,0,0, 0, 0,0,1,0, 0,0,0,0,0);
        @(negedge clk_i);
        #2 reset_n_i = 1'b0;
        #1 expect_state(tag, r);
        #1 reset_n_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t r;
        idle_inputs();

        // Directed vector table.
        // early commit -> packet next cycle, yumi empties
        vecs.push_back(v(1,39'h80000000,5,0,64'h1234, 0,0,0, 0, 1,1,1,0, 1,39'h80000000,1,5,64'h1234));
        vecs.push_back(v(0,0,0,0,0, 0,0,0, 1, 0,0,1,0, 0,0,0,0,0));
        // late commit rd7, writeback three cycles later
        vecs.push_back(v(1,39'h80000004,7,1,64'h5555, 0,0,0, 0, 0,1,1,0, 0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0, 0,0,0, 0, 0,1,1,0, 0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0, 0,0,0, 0, 0,1,1,0, 0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0, 1,7,64'hdead, 0, 1,1,1,0, 1,39'h80000004,1,7,64'hdead));
        vecs.push_back(v(0,0,0,0,0, 0,0,0, 1, 0,0,1,0, 0,0,0,0,0));
        // table[7] was consumed: a new late rd7 commit must stall
        vecs.push_back(v(1,39'h80000008,7,1,0, 0,0,0, 0, 0,1,1,0, 0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0, 1,7,64'hbeef, 0, 1,1,1,0, 1,39'h80000008,1,7,64'hbeef));
        vecs.push_back(v(0,0,0,0,0, 0,0,0, 1, 0,0,1,0, 0,0,0,0,0));
        // out-of-order late writebacks, in-order packets
        vecs.push_back(v(1,39'h80000010,3,1,0, 0,0,0, 0, 0,1,1,0, 0,0,0,0,0));
        vecs.push_back(v(1,39'h80000014,4,1,0, 0,0,0, 0, 0,2,1,0, 0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0, 1,4,64'h44, 0, 0,2,1,0, 0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0, 1,3,64'h33, 0, 1,2,1,0, 1,39'h80000010,1,3,64'h33));
        vecs.push_back(v(0,0,0,0,0, 0,0,0, 1, 1,1,1,0, 1,39'h80000014,1,4,64'h44));
        vecs.push_back(v(0,0,0,0,0, 0,0,0, 1, 0,0,1,0, 0,0,0,0,0));
        // rd=0 normalisation
        vecs.push_back(v(1,39'h80000018,0,1,64'hffff, 0,0,0, 0, 1,1,1,0, 1,39'h80000018,0,0,64'h0));
        vecs.push_back(v(0,0,0,0,0, 0,0,0, 1, 0,0,1,0, 0,0,0,0,0));
        // same-edge late write and clear of rd10: write wins, no error
        vecs.push_back(v(1,39'h8000001c,10,1,0, 0,0,0, 0, 0,1,1,0, 0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0, 1,10,64'ha1, 0, 1,1,1,0, 1,39'h8000001c,1,10,64'ha1));
        vecs.push_back(v(0,0,0,0,0, 1,10,64'ha2, 1, 0,0,1,0, 0,0,0,0,0));
        vecs.push_back(v(1,39'h80000020,10,1,0, 0,0,0, 0, 1,1,1,0, 1,39'h80000020,1,10,64'ha2));
        vecs.push_back(v(0,0,0,0,0, 0,0,0, 1, 0,0,1,0, 0,0,0,0,0));
        // push + pop when not full keeps count
        vecs.push_back(v(1,39'h80000024,1,0,64'h11, 0,0,0, 0, 1,1,1,0, 1,39'h80000024,1,1,64'h11));
        vecs.push_back(v(1,39'h80000028,2,0,64'h22, 0,0,0, 1, 1,1,1,0, 1,39'h80000028,1,2,64'h22));
        vecs.push_back(v(0,0,0,0,0, 0,0,0, 1, 0,0,1,0, 0,0,0,0,0));
        // fill to full, drop 9th, push+yumi while full, drain with wrap
        for (int i = 0; i < 8; i++)
            vecs.push_back(v(1,39'h100 + 39'(4*i),5'(i+1),0,64'(i), 0,0,0, 0,
                             1,i+1,(i != 7),0, 1,39'h100,1,1,64'h0));
        vecs.push_back(v(1,39'h200,9,0,64'h99, 0,0,0, 0, 1,8,0,1, 1,39'h100,1,1,64'h0));
        vecs.push_back(v(1,39'h204,10,0,64'haa, 0,0,0, 1, 1,7,1,1, 1,39'h104,1,2,64'h1));
        for (int i = 1; i < 8; i++)
            vecs.push_back(v(0,0,0,0,0, 0,0,0, 1, (i < 7),7-i,1,1,
                             (i < 7),39'h100 + 39'(4*(i+1)),1,5'(i+2),64'(i+1)));

        // Reset state, checked while reset is held.
        #3;
        r = v(0,0,0,0,0, 0,0,0, 0, 0,0,1,0, 0,0,0,0,0);
        expect_state("reset", r);
        @(negedge clk_i);
        reset_n_i = 1'b1;

        foreach (vecs[i]) apply($sformatf("v%0d", i), vecs[i]);

        // Mid-operation async reset discards buffer, table and error.
        apply("rs.a", v(1,39'h300,1,0,64'h1, 0,0,0, 0, 1,1,1,1, 0,0,0,0,0));
        apply("rs.b", v(1,39'h304,2,0,64'h2, 0,0,0, 0, 1,2,1,1, 0,0,0,0,0));
        apply("rs.c", v(1,39'h308,3,0,64'h3, 1,9,64'h99, 0, 1,3,1,1, 0,0,0,0,0));
        @(negedge clk_i);
        #2 reset_n_i = 1'b0;
        #1 expect_state("rs.low", v(0,0,0,0,0, 0,0,0, 0, 0,0,1,0, 0,0,0,0,0));
        // Release and present a late rd9 commit for the very first edge.
        #1 reset_n_i = 1'b1;
        drive(v(1,39'h30c,9,1,0, 0,0,0, 0, 0,0,0,0, 0,0,0,0,0));
        @(posedge clk_i);
        #1 idle_inputs();
        expect_state("rs.first", v(0,0,0,0,0, 0,0,0, 0, 0,1,1,0, 0,0,0,0,0));
        apply("rs.stall", v(0,0,0,0,0, 0,0,0, 0, 0,1,1,0, 0,0,0,0,0));
        apply("rs.wb", v(0,0,0,0,0, 1,9,64'h1999, 0, 1,1,1,0, 1,39'h30c,1,9,64'h1999));
        apply("rs.pop", v(0,0,0,0,0, 0,0,0, 1, 0,0,1,0, 0,0,0,0,0));

        // Late write onto a still-valid register: overwrite and flag.
        apply("ow.a", v(0,0,0,0,0, 1,12,64'hd1, 0, 0,0,1,0, 0,0,0,0,0));
        apply("ow.b", v(0,0,0,0,0, 1,12,64'hd2, 0, 0,0,1,1, 0,0,0,0,0));
        apply("ow.c", v(1,39'h310,12,1,0, 0,0,0, 0, 1,1,1,1, 1,39'h310,1,12,64'hd2));

        // Yumi with no packet: ignored, flagged.
        async_reset_pulse("ym.rst");
        apply("ym.a", v(0,0,0,0,0, 0,0,0, 1, 0,0,1,1, 0,0,0,0,0));

        // Late write to x0 is ignored and does not flag.
        async_reset_pulse("x0.rst");
        apply("x0.a", v(0,0,0,0,0, 1,0,64'h7, 0, 0,0,1,0, 0,0,0,0,0));
        apply("x0.b", v(0,0,0,0,0, 1,0,64'h8, 0, 0,0,1,0, 0,0,0,0,0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bp_nonsynth_commit_packer.md
BP_NONSYNTH_COMMIT_PACKER -- requirements
Module: bp_nonsynth_commit_packer

Interface
REQ-001 SHALL have parameter vaddr_width_p, default 39, commit PC width.
REQ-002 SHALL have parameter instr_width_p, default 32, instruction width.
REQ-003 SHALL have parameter dword_width_p, default 64, writeback data width.
REQ-004 SHALL have parameter els_p, default 8, commit buffer depth (power of two, >=2).
REQ-005 SHALL use one clock; reset is asynchronous and active-low. Ports clk_i and reset_n_i.
REQ-006 Ports, listed as name, direction, width, meaning:
- clk_i  in  1  clock
- reset_n_i  in  1  async active-low reset
- commit_v_i  in  1  instruction retired this cycle
- commit_pc_i  in  vaddr_width_p  retired PC
- commit_instr_i  in  instr_width_p  retired instruction
- commit_rd_w_v_i  in  1  instruction writes integer rd
- commit_rd_addr_i  in  5  rd index
- commit_late_i  in  1  rd data arrives later via late port
- commit_data_i  in  dword_width_p  early rd data, valid when ~commit_late_i
- late_wb_v_i  in  1  late writeback strobe
- late_wb_addr_i  in  5  late writeback rd index
- late_wb_data_i  in  dword_width_p  late writeback data
- ready_o  out  1  buffer not full
- pkt_v_o  out  1  packet valid
- pkt_yumi_i  in  1  consumer takes packet; legal only when pkt_v_o
- pkt_pc_o  out  vaddr_width_p  packet PC
- pkt_instr_o  out  instr_width_p  packet instruction
- pkt_rd_w_v_o  out  1  packet carries rd write
- pkt_rd_addr_o  out  5  packet rd index
- pkt_rd_data_o  out  dword_width_p  packet rd data
- count_o  out  clog2(els_p)+1  buffered commit count
- err_o  out  1  sticky protocol error

Function
REQ-007 SHALL push {pc, instr, rd_w_v, rd_addr, late, data} into an in-order els_p-entry FIFO on commit_v_i & ready_o.
REQ-008 SHALL set ready_o = (count_o != els_p); a pop in the same cycle SHALL NOT free space for a push.
REQ-009 SHALL drop commit_v_i while full and set err_o.
REQ-010 SHALL normalise rd_addr 0: stored rd_w_v = 0, late = 0, data = 0.
REQ-011 SHALL keep a 32-entry late table (data + valid bit per register). late_wb_v_i writes data and sets valid on the next edge. Writes to x0 are ignored.
REQ-012 SHALL assert pkt_v_o when the FIFO is non-empty and (head.late = 0 or table[head.rd_addr].valid = 1), combinationally from registered state.
REQ-013 SHALL drive pkt_rd_data_o = head.data when head.late = 0, else table[head.rd_addr].data. All pkt_* fields come from the head.
REQ-014 SHALL pop the head on pkt_yumi_i and, if head.late, clear table[head.rd_addr].valid on the same edge.
REQ-015 Latency: a commit at edge N gives pkt_v_o after edge N when the FIFO is empty and data is early. A late writeback at edge M gives pkt_v_o after edge M at the earliest. There is no same-cycle bypass.
REQ-016 Simultaneous late write and clear to the same register: the write SHALL win (valid stays 1, new data).
REQ-017 A late write to a register whose valid = 1 and which is not being cleared that cycle SHALL overwrite the data and set err_o.
REQ-018 pkt_yumi_i while pkt_v_o = 0 SHALL be ignored and set err_o.
REQ-019 Simultaneous push and pop when not full SHALL leave count_o unchanged.
REQ-020 FIFO pointers SHALL wrap modulo els_p.
REQ-021 count_o SHALL saturate at neither end; push-when-full and pop-when-empty are blocked.

Reset
REQ-022 While reset_n_i = 0: FIFO empty, all table valid bits 0, count_o = 0, pkt_v_o = 0, ready_o = 1, err_o = 0. Table data is don't-care.
REQ-023 Reset asserted mid-operation SHALL discard all buffered commits and pending late data immediately, without waiting for a clock.
REQ-024 The first push SHALL be accepted on the first rising edge after reset_n_i rises.

Verification
REQ-025 Early commit pc=0x80000000, rd=5, data=0x1234 -> next cycle pkt_v_o=1, rd_w_v=1, rd=5, data=0x1234. Yumi -> count_o=0.
REQ-026 Late commit rd=7, then late_wb rd=7 data=0xdead three cycles later -> pkt_v_o low until the edge after the late write, then data=0xdead. Table[7].valid clears on yumi.
REQ-027 Two late commits rd=3 then rd=4; late_wb 4 arrives before 3 -> no packet until 3 arrives. Packets then emitted in order 3, 4 with correct data.
REQ-028 Fill 8 commits with no yumi -> ready_o=0, count_o=8. 9th commit -> dropped, err_o=1. Push+yumi while full -> count_o=7.
REQ-029 Commit rd=0, late=1, data=0xffff -> packet emitted next cycle with rd_w_v=0, data=0.
REQ-030 Buffer 3 entries with table[9] valid, pulse reset_n_i low between edges -> count_o=0, pkt_v_o=0, err_o=0 immediately. After release, a late commit rd=9 stalls until a new late write.
